// File: rtl/led_chaser.sv
// Prescaled LED chaser with left/right/bounce/bar-fill patterns, run/pause and step strobe.
// Optional 25% duty trailing LED is enabled by defining CHASER_TRAIL_EN.
module led_chaser #(
  parameter  int N_LEDS = 8,
  parameter  int DIV    = 6_250_000,
  localparam int POS_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] led,
  output logic [POS_W-1:0]  pos,
  output logic              step
);

  localparam int CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N_LEDS - 1);
  // Turnaround targets; guarded so a single-LED build never sees a negative constant.
  localparam logic [POS_W-1:0]  POS_TURN  = POS_W'((N_LEDS > 1) ? N_LEDS - 2 : 0);
  localparam logic [POS_W-1:0]  POS_ONE   = POS_W'((N_LEDS > 1) ? 1 : 0);
  localparam logic [N_LEDS-1:0] LED_RESET = N_LEDS'(1);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              tick;
  logic [POS_W-1:0]  pos_reg, pos_next, pos_inc, pos_dec;
  dir_t              dir_reg, dir_next;
  logic              step_reg;
  logic              fill_tick;
  logic [N_LEDS-1:0] led_reg, led_next;
  logic [N_LEDS-1:0] onehot_pos, bar_pos;

  // Prescaler: holds its count while paused so resuming does not restart the interval.
  always_comb begin
    cnt_next = cnt_reg;
    tick     = 1'b0;
    if (en) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
        tick     = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign pos_inc = (pos_reg == POS_LAST) ? '0 : pos_reg + 1'b1;
  assign pos_dec = (pos_reg == '0) ? POS_LAST : pos_reg - 1'b1;

  // Mode is only looked at in the tick cycle; an unknown mode holds position and direction.
  always_comb begin
    pos_next  = pos_reg;
    dir_next  = dir_reg;
    fill_tick = 1'b0;
    if (tick) begin
      case (mode)
        2'b00: begin
          pos_next = pos_inc;
          dir_next = UP;
        end
        2'b01: begin
          pos_next = pos_dec;
          dir_next = DOWN;
        end
        2'b10: begin
          if (dir_reg == UP) begin
            if (pos_reg == POS_LAST) begin
              pos_next = POS_TURN;
              dir_next = DOWN;
            end else begin
              pos_next = pos_reg + 1'b1;
            end
          end else begin
            if (pos_reg == '0) begin
              pos_next = POS_ONE;
              dir_next = UP;
            end else begin
              pos_next = pos_reg - 1'b1;
            end
          end
        end
        2'b11: begin
          pos_next  = pos_inc;
          dir_next  = UP;
          fill_tick = 1'b1;
        end
        default: ;
      endcase
      if (N_LEDS == 1) pos_next = '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LEDS; gi++) begin : g_pattern
      assign onehot_pos[gi] = (pos_next == POS_W'(gi));
      assign bar_pos[gi]    = (POS_W'(gi) <= pos_next);
    end
  endgenerate

`ifdef CHASER_TRAIL_EN
  logic [POS_W-1:0]  prev_reg, prev_next;
  logic [1:0]        pwm_reg, pwm_next;
  logic              fill_reg, fill_next;
  logic [N_LEDS-1:0] onehot_prev;

  assign prev_next = tick ? pos_reg : prev_reg;
  assign pwm_next  = pwm_reg + 2'd1;
  // Bar mode is latched at the tick so a later mode change cannot alter the display.
  assign fill_next = tick ? fill_tick : fill_reg;

  generate
    for (gi = 0; gi < N_LEDS; gi++) begin : g_trail
      assign onehot_prev[gi] = (prev_next == POS_W'(gi));
    end
  endgenerate

  always_comb begin
    led_next = onehot_pos;
    if (fill_next) begin
      led_next = bar_pos;
    end else if (pwm_next == 2'd0) begin
      led_next = onehot_pos | onehot_prev;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg <= '0;
      pwm_reg  <= 2'd0;
      fill_reg <= 1'b0;
    end else begin
      prev_reg <= prev_next;
      pwm_reg  <= pwm_next;
      fill_reg <= fill_next;
    end
  end
`else
  assign led_next = fill_tick ? bar_pos : onehot_pos;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      pos_reg  <= '0;
      dir_reg  <= UP;
      step_reg <= 1'b0;
      led_reg  <= LED_RESET;
    end else begin
      cnt_reg  <= cnt_next;
      pos_reg  <= pos_next;
      dir_reg  <= dir_next;
      step_reg <= tick;
`ifdef CHASER_TRAIL_EN
      led_reg  <= led_next;
`else
      if (tick) led_reg <= led_next;
`endif
    end
  end

  assign led  = led_reg;
  assign pos  = pos_reg;
  assign step = step_reg;

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser: 8-LED/DIV=4 instance for all modes, pause and reset,
// plus a 5-LED/DIV=1 instance for bar fill stepping every clock.
module tb_led_chaser;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] led;
  logic [2:0] pos;
  logic       step;

  logic       en5;
  logic [1:0] mode5;
  logic [4:0] led5;
  logic [2:0] pos5;
  logic       step5;

  int checks = 0;
  int errors = 0;

  led_chaser #(.N_LEDS(8), .DIV(4)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .led  (led),
    .pos  (pos),
    .step (step)
  );

  led_chaser #(.N_LEDS(5), .DIV(1)) u_fill5 (
    .clk  (clk),
    .rst  (rst),
    .en   (en5),
    .mode (mode5),
    .led  (led5),
    .pos  (pos5),
    .step (step5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Number of falling edges until step is seen high; -1 if it never comes.
  task automatic wait_step(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (step) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int cyc;
  logic [2:0] bounce_pos [15] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                                  3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
  logic [7:0] fill8_led [8]   = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};
  logic [4:0] fill5_led [5]   = '{5'h03, 5'h07, 5'h0F, 5'h1F, 5'h01};
  logic [7:0] right_led [3]   = '{8'h80, 8'h40, 8'h20};
  logic [2:0] right_pos [3]   = '{3'd7, 3'd6, 3'd5};

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    mode  = 2'b00;
    en5   = 1'b0;
    mode5 = 2'b11;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_led", 32'(led), 32'h01);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_led5", 32'(led5), 32'h01);
    rst = 1'b0;

    // Bar fill on 5 LEDs, one step per clock
    en5 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("fill5_led", 32'(led5), 32'(fill5_led[k]));
      check("fill5_step", 32'(step5), 32'd1);
    end
    en5 = 1'b0;
    @(negedge clk);
    check("fill5_pause", 32'(step5), 32'd0);
    check("fill5_hold", 32'(led5), 32'h01);

    // LEFT: step every 4 clocks, full wrap
    en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      wait_step(cyc);
      check("left_period", 32'(cyc), 32'd4);
      check("left_pos", 32'(pos), 32'(k % 8));
      check("left_led", 32'(led), 32'h1 << (k % 8));
    end

    // RIGHT from reset
    mode = 2'b01;
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      wait_step(cyc);
      check("right_period", 32'(cyc), 32'd4);
      check("right_pos", 32'(pos), 32'(right_pos[k]));
      check("right_led", 32'(led), 32'(right_led[k]));
    end

    // BOUNCE from reset: endpoints once per sweep
    mode = 2'b10;
    pulse_reset();
    for (int k = 0; k < 15; k++) begin
      wait_step(cyc);
      check("bounce_pos", 32'(pos), 32'(bounce_pos[k]));
      check("bounce_led", 32'(led), 32'h1 << bounce_pos[k]);
    end

    // FILL on 8 LEDs
    mode = 2'b11;
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      wait_step(cyc);
      check("fill8_led", 32'(led), 32'(fill8_led[k]));
    end

    // Pause two cycles after a step, resume, then switch mode mid-interval
    mode = 2'b00;
    pulse_reset();
    wait_step(cyc);
    check("pause_pre_pos", 32'(pos), 32'd1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("pause_step", 32'(step), 32'd0);
      check("pause_led", 32'(led), 32'h02);
    end
    check("pause_pos", 32'(pos), 32'd1);
    en = 1'b1;
    wait_step(cyc);
    check("resume_delay", 32'(cyc), 32'd2);
    check("resume_led", 32'(led), 32'h04);
    @(negedge clk);
    mode = 2'b01;
    @(negedge clk);
    check("modechg_hold", 32'(led), 32'h04);
    wait_step(cyc);
    check("modechg_cyc", 32'(cyc), 32'd2);
    check("modechg_pos", 32'(pos), 32'd1);
    check("modechg_led", 32'(led), 32'h02);

    // Asynchronous reset between clock edges, right while step is high
    mode = 2'b00;
    pulse_reset();
    wait_step(cyc);
    check("arst_pre_step", 32'(step), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_led", 32'(led), 32'h01);
    check("arst_pos", 32'(pos), 32'd0);
    check("arst_step", 32'(step), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_step(cyc);
    check("arst_restart", 32'(cyc), 32'd4);
    check("arst_pos1", 32'(pos), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
